// File: rtl/fifo_sc_m.sv
// fifo_sc_m: single-clock first-word-fall-through FIFO with a typed item,
// occupancy count, programmable almost-full/almost-empty thresholds, flush,
// and sticky overflow/underflow flags. All status outputs are registered.
//
// Handshake: a push is accepted on a rising edge when push & ~full, and a pop
// is accepted when pop & ~empty. Neither is accepted in a flush cycle. head
// carries the oldest item whenever empty==0. It is driven only from registered
// state, so it has no combinational path from push or pop.
module fifo_sc_m #(
  parameter type   DATA_ITEM_TYPE = logic,
  parameter int    DEPTH          = 32,
  parameter int    AF_THRESH      = DEPTH - 2,
  parameter int    AE_THRESH      = 1,
  parameter string MEMTYPE        = "auto",
  localparam int   CW             = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  DATA_ITEM_TYPE tail,
  input  logic          push,
  output DATA_ITEM_TYPE head,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sc_m: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_sc_m: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sc_m: AE_THRESH must be in 0..DEPTH-1");
  end

  DATA_ITEM_TYPE mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;

  // Acceptance, pointer/count next state, and sticky error flags.
  always_comb begin
    push_ok  = push & ~full_q & ~flush;
    pop_ok   = pop & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = ovf_q | (push & full_q & ~flush);
    udf_d    = udf_q | (pop & empty_q & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer, count and status registers; status follows the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array, written at the write pointer on an accepted push; no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= tail;
    end
  end

  if (MEMTYPE == "distributed") begin : g_dist
    DATA_ITEM_TYPE hold_q;

    // Remember the presented head so it persists once the FIFO drains.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        hold_q <= '0;
      end else if (!empty_q) begin
        hold_q <= mem_q[rd_ptr_q];
      end
    end

    assign head = empty_q ? hold_q : mem_q[rd_ptr_q];
  end else begin : g_prefetch
    DATA_ITEM_TYPE head_q;

    // Prefetch the item that will be oldest after this edge. When no stored
    // item survives the pop, the new head is the item being written now.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        head_q <= '0;
      end else if ((count_d != '0) && (empty_q || pop_ok)) begin
        head_q <= (count_q == CW'(pop_ok)) ? tail : mem_q[rd_ptr_d];
      end
    end

    assign head = head_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sc_m.sv
// tb_fifo_sc_m: directed bench for fifo_sc_m (8-bit items, DEPTH=8, AF=6, AE=1).
module tb_fifo_sc_m;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [W-1:0]  tail = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  head;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  fifo_sc_m #(
    .DATA_ITEM_TYPE(logic [W-1:0]),
    .DEPTH(8),
    .AF_THRESH(6),
    .AE_THRESH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .tail(tail),
    .push(push),
    .head(head),
    .pop(pop),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_st(input string tag, input int cnt, input bit emp, input bit ful,
                        input bit ae, input bit af, input bit ovf, input bit udf);
    chk({tag, "_count"}, 32'(count), 32'(cnt));
    chk({tag, "_empty"}, 32'(empty), 32'(emp));
    chk({tag, "_full"}, 32'(full), 32'(ful));
    chk({tag, "_ae"}, 32'(almost_empty), 32'(ae));
    chk({tag, "_af"}, 32'(almost_full), 32'(af));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    chk({tag, "_udf"}, 32'(underflow), 32'(udf));
  endtask

  // One clock of stimulus; acc says whether the push is expected to be accepted.
  task automatic step(input bit p, input logic [W-1:0] d, input bit q, input bit f, input bit acc);
    push  = p;
    tail  = d;
    pop   = q;
    flush = f;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every accepted pop must deliver the oldest expected item.
  always @(negedge clk) begin
    if (!rst && !flush && pop && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: got 0x%0h expected nothing queued", head);
      end else begin
        chk("pop_data", 32'(head), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset
    do_reset();
    chk_st("rst", 0, 1, 0, 1, 0, 0, 0);
    chk("rst_head", 32'(head), 32'h0);

    // 2. fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0, 1'b1);
      chk_st("fill", i, 0, (i == 8), (i <= 1), (i >= 6), 0, 0);
      if (i == 1) chk("fill_head", 32'(head), 32'h01);
    end

    // 3. push 0xAA while full with pop: push dropped, 0x01 popped
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk_st("ovf", 7, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("drain", 0, 1, 0, 1, 0, 1, 0);
    chk("drain_head", 32'(head), 32'h08);

    // 4. push+pop while empty: only push accepted, underflow set
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk_st("udf", 1, 0, 0, 1, 0, 1, 1);
    chk("udf_head", 32'(head), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("udf_pop", 0, 1, 0, 1, 0, 1, 1);
    chk("udf_hold", 32'(head), 32'h55);

    // 5. streaming at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    chk("stream_pre", 32'(count), 32'd3);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, W'(8'h13 + i), 1'b1, 1'b0, 1'b1);
      chk("stream_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("stream_end", 0, 1, 0, 1, 0, 1, 1);

    // 6. flush at count 5 with a push: contents and push discarded, flags kept
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk_st("pre_flush", 5, 0, 0, 0, 0, 1, 1);
    chk("pre_flush_head", 32'(head), 32'h60);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk_st("flush", 0, 1, 0, 1, 0, 1, 1);
    chk("flush_head", 32'(head), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("flush_idle", 32'(count), 32'd0);

    // 7. reset mid-operation clears everything including sticky flags
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk_st("rst2", 0, 1, 0, 1, 0, 0, 0);
    chk("rst2_head", 32'(head), 32'h00);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    chk("post_rst_head", 32'(head), 32'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("post_rst", 0, 1, 0, 1, 0, 0, 0);

    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
